// File: rtl/video_pkg.sv
// Shared types and geometry for the character renderer.
package video_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      WAIT  = 2'd2,
      DRAW  = 2'd3
   } state_t;

   localparam int GLYPH_W       = 8;
   localparam int GLYPH_H       = 8;
   localparam int GLYPH_BITS    = GLYPH_W * GLYPH_H;
   localparam int NUM_CHARS_DEF = 40;
   localparam int COLS_DEF      = 40;
   localparam int ROWS_DEF      = 30;
   localparam int SCREEN_W_DEF  = COLS_DEF * GLYPH_W;
   localparam int FB_AW_DEF     = 17;

endpackage

// File: rtl/char_render_ctrl_serializer.sv
// Holds one 8x8 glyph and walks it row-major, one pixel per taken write.
module glyph_serializer
   import video_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load,
   input  logic [GLYPH_BITS-1:0] load_data,
   input  logic                  advance,
   output logic [5:0]            pix_idx,
   output logic                  pix,
   output logic                  last
);

   logic [GLYPH_BITS-1:0] glyph_q, glyph_d;
   logic [5:0]            idx_q, idx_d;

   always_comb begin
      glyph_d = glyph_q;
      idx_d   = idx_q;
      if (load) begin
         glyph_d = load_data;
         idx_d   = 6'd0;
      end else if (advance) begin
         idx_d = idx_q + 6'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         glyph_q <= '0;
         idx_q   <= 6'd0;
      end else begin
         glyph_q <= glyph_d;
         idx_q   <= idx_d;
      end
   end

   assign pix_idx = idx_q;
   // bit 63 is the top-left pixel, so 63-p is simply the complement of p
   assign pix     = glyph_q[~idx_q];
   assign last    = (idx_q == 6'd63);

endmodule

// File: rtl/char_render_ctrl.sv
// Draw-character sequencer: one glyph ROM read, then 64 pixel writes.
//
// state | meaning
// IDLE  | ready for a request; range check on accept
// FETCH | glyph ROM read enable (suppressed for blank codes)
// WAIT  | ROM data returns; glyph latched at end of cycle
// DRAW  | one pixel write per cycle, held while fb_stall
module char_render_ctrl
   import video_pkg::*;
#(
   parameter int NUM_CHARS = NUM_CHARS_DEF,
   parameter int COLS      = COLS_DEF,
   parameter int ROWS      = ROWS_DEF,
   parameter int SCREEN_W  = SCREEN_W_DEF,
   parameter int FB_AW     = FB_AW_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [5:0]            req_char,
   input  logic [5:0]            req_col,
   input  logic [4:0]            req_row,
   output logic                  charprint,
   output logic [5:0]            character,
   input  logic [GLYPH_BITS-1:0] vdata,
   output logic                  fb_we,
   output logic [FB_AW-1:0]      fb_addr,
   output logic                  fb_data,
   input  logic                  fb_stall,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   state_t     state_q, state_d;
   logic [5:0] code_q, code_d;
   logic [5:0] col_q, col_d;
   logic [4:0] row_q, row_d;
   logic [5:0] character_q, character_d;
   logic       charprint_q, charprint_d;
   logic       fb_we_q, fb_we_d;
   logic       busy_q, busy_d;
   logic       req_ready_q, req_ready_d;
   logic       err_q, err_d;

   logic                  in_range, blank, taken, last, pix;
   logic [5:0]            pix_idx;
   logic [GLYPH_BITS-1:0] load_data;
   logic [FB_AW-1:0]      pix_x, pix_y;

   assign in_range  = (req_col < 6'(COLS)) && (req_row < 5'(ROWS));
   assign blank     = (code_q >= 6'(NUM_CHARS));
   assign taken     = (state_q == DRAW) && !fb_stall;
   assign load_data = blank ? '0 : vdata;

   glyph_serializer u_ser (
      .clk       (clk),
      .reset     (reset),
      .load      (state_q == WAIT),
      .load_data (load_data),
      .advance   (taken),
      .pix_idx   (pix_idx),
      .pix       (pix),
      .last      (last)
   );

   always_comb begin
      state_d     = state_q;
      code_d      = code_q;
      col_d       = col_q;
      row_d       = row_q;
      character_d = character_q;
      err_d       = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               if (in_range) begin
                  state_d     = FETCH;
                  code_d      = req_char;
                  col_d       = req_col;
                  row_d       = req_row;
                  character_d = req_char;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         FETCH:   state_d = WAIT;
         WAIT:    state_d = DRAW;
         DRAW:    if (taken && last) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // blank codes never touch the ROM; the cell is cleared with zeros
      charprint_d = (state_d == FETCH) && (code_d < 6'(NUM_CHARS));
      fb_we_d     = (state_d == DRAW);
      busy_d      = (state_d != IDLE);
      req_ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         code_q      <= 6'd0;
         col_q       <= 6'd0;
         row_q       <= 5'd0;
         character_q <= 6'd0;
         charprint_q <= 1'b0;
         fb_we_q     <= 1'b0;
         busy_q      <= 1'b0;
         req_ready_q <= 1'b1;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         code_q      <= code_d;
         col_q       <= col_d;
         row_q       <= row_d;
         character_q <= character_d;
         charprint_q <= charprint_d;
         fb_we_q     <= fb_we_d;
         busy_q      <= busy_d;
         req_ready_q <= req_ready_d;
         err_q       <= err_d;
      end
   end

   assign pix_y   = FB_AW'({row_q, pix_idx[5:3]});
   assign pix_x   = FB_AW'({col_q, pix_idx[2:0]});
   assign fb_addr = pix_y * FB_AW'(SCREEN_W) + pix_x;
   assign fb_data = pix;

   assign req_ready = req_ready_q;
   assign charprint = charprint_q;
   assign character = character_q;
   assign fb_we     = fb_we_q;
   assign busy      = busy_q;
   assign err       = err_q;
   assign done      = taken && last;

endmodule

// File: tb/tb_char_render_ctrl.sv
// Directed bench for char_render_ctrl with a pixel-list scoreboard and glyph ROM model.
module tb_char_render_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [5:0]  req_char = '0;
   logic [5:0]  req_col = '0;
   logic [4:0]  req_row = '0;
   logic        charprint;
   logic [5:0]  character;
   logic [63:0] vdata = '0;
   logic        fb_we;
   logic [16:0] fb_addr;
   logic        fb_data;
   logic        fb_stall = 1'b0;
   logic        busy, done, err;

   char_render_ctrl dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_char(req_char), .req_col(req_col), .req_row(req_row),
      .charprint(charprint), .character(character), .vdata(vdata),
      .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data), .fb_stall(fb_stall),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   function automatic logic [63:0] rom(input logic [5:0] code);
      if (code == 6'd5) return 64'h8000_0000_0000_0001;
      return {8{code, 2'b01}};
   endfunction

   function automatic int exp_addr(input int col, input int row, input int p);
      return (row * 8 + p / 8) * 320 + col * 8 + p % 8;
   endfunction

   // Registered glyph ROM: data appears one cycle after the read enable, junk otherwise
   always @(posedge clk) begin
      logic       cp_s;
      logic [5:0] ch_s;
      cp_s = charprint;
      ch_s = character;
      #1;
      vdata = cp_s ? rom(ch_s) : {$urandom, $urandom};
   end

   typedef struct {
      int   addr;
      logic data;
   } wr_t;
   wr_t exq[$];

   logic [5:0] cp_code;
   int n_cp, n_err, n_we, n_taken, n_ones;
   int cp_cyc, err_cyc, done_cyc, first_we, first_addr, last_addr, acc;

   always @(negedge clk) begin
      if (!reset) begin
         if (done && done_cyc < 0) done_cyc = cyc;
         if (charprint) begin
            n_cp++;
            cp_cyc = cyc;
            check("character", character, cp_code);
         end
         if (err) begin
            n_err++;
            if (err_cyc < 0) err_cyc = cyc;
         end
         if (fb_we) begin
            n_we++;
            if (first_we < 0) first_we = cyc;
            if (exq.size() == 0) begin
               check("unexpected_write", fb_we, 0);
            end else if (fb_stall) begin
               check("stall_addr", fb_addr, exq[0].addr);
               check("stall_data", fb_data, exq[0].data);
               check("stall_done", done, 0);
            end else begin
               check("addr", fb_addr, exq[0].addr);
               check("data", fb_data, exq[0].data);
               check("done", done, exq.size() == 1);
               if (fb_data) n_ones++;
               if (n_taken == 0) first_addr = fb_addr;
               last_addr = fb_addr;
               n_taken++;
               void'(exq.pop_front());
            end
         end else begin
            check("done_idle", done, 0);
         end
      end
   end

   task automatic run_req(input logic [5:0] ch, input logic [5:0] col, input logic [4:0] row,
                          input int st0, input int stn, input int abort_at);
      logic [63:0] g;
      bit          timed_out;
      n_cp = 0; n_err = 0; n_we = 0; n_taken = 0; n_ones = 0;
      cp_cyc = -1; err_cyc = -1; done_cyc = -1; first_we = -1;
      first_addr = -1; last_addr = -1;
      g = (ch < 40) ? rom(ch) : 64'h0;
      if (col < 40 && row < 30)
         for (int p = 0; p < 64; p++) exq.push_back('{addr: exp_addr(col, row, p), data: g[63-p]});
      cp_code   = ch;
      req_valid = 1'b1;
      req_char  = ch;
      req_col   = col;
      req_row   = row;
      @(posedge clk); #1;
      acc       = cyc;
      req_valid = 1'b0;
      req_char  = 6'($urandom);
      req_col   = 6'($urandom);
      req_row   = 5'($urandom);
      timed_out = 1'b1;
      for (int k = 1; k < 300; k++) begin
         fb_stall = (k - 3 >= st0) && (k - 3 < st0 + stn);
         if (abort_at >= 0 && n_taken == abort_at) begin
            timed_out = 1'b0;
            break;
         end
         @(posedge clk); #1;
         if (done_cyc >= 0 || n_err > 0) begin
            timed_out = 1'b0;
            break;
         end
      end
      fb_stall = 1'b0;
      check("timeout", timed_out, 0);
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      #3;
      check("rst_we", fb_we, 0);
      check("rst_busy", busy, 0);
      check("rst_cp", charprint, 0);
      check("rst_addr", fb_addr, 0);
      check("rst_char", character, 0);
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0;
      idle_cycles(2);
      check("rst_ready", req_ready, 1);
      check("rst_err", err, 0);

      // char 5 at (0,0): only the two corner pixels are lit
      run_req(6'd5, 6'd0, 5'd0, 1000, 0, -1);
      check("t1_ready", req_ready, 1);
      check("t1_busy", busy, 0);
      check("t1_cp_cycle", cp_cyc - acc, 0);
      check("t1_n_cp", n_cp, 1);
      check("t1_first_we", first_we - acc, 2);
      check("t1_done_cyc", done_cyc - acc, 65);
      check("t1_taken", n_taken, 64);
      check("t1_ones", n_ones, 2);
      check("t1_first_addr", first_addr, 0);
      check("t1_last_addr", last_addr, 2247);
      idle_cycles(3);
      check("t1_no_extra_we", n_we, 64);

      // bottom-right cell
      run_req(6'd3, 6'd39, 5'd29, 1000, 0, -1);
      check("t2_first_addr", first_addr, 74552);
      check("t2_last_addr", last_addr, 76799);
      check("t2_taken", n_taken, 64);
      check("t2_err", n_err, 0);

      // out-of-range column and row
      run_req(6'd2, 6'd40, 5'd0, 1000, 0, -1);
      idle_cycles(3);
      check("t3c_err", n_err, 1);
      check("t3c_err_cyc", err_cyc - acc, 0);
      check("t3c_cp", n_cp, 0);
      check("t3c_we", n_we, 0);
      check("t3c_ready", req_ready, 1);
      run_req(6'd2, 6'd0, 5'd30, 1000, 0, -1);
      idle_cycles(3);
      check("t3r_err", n_err, 1);
      check("t3r_cp", n_cp, 0);
      check("t3r_we", n_we, 0);
      check("t3r_busy", busy, 0);

      // blank glyph clears the cell without a ROM read
      run_req(6'd45, 6'd1, 5'd1, 1000, 0, -1);
      check("t4_cp", n_cp, 0);
      check("t4_taken", n_taken, 64);
      check("t4_ones", n_ones, 0);
      check("t4_first_addr", first_addr, 2568);
      check("t4_done_cyc", done_cyc - acc, 65);

      // 5-cycle stall in the middle of the draw
      run_req(6'd7, 6'd3, 5'd2, 10, 5, -1);
      check("t5_taken", n_taken, 64);
      check("t5_we_cycles", n_we, 69);
      check("t5_done_cyc", done_cyc - acc, 70);

      // reset while drawing pixel 20
      run_req(6'd9, 6'd10, 5'd10, 1000, 0, 20);
      #2;
      reset = 1'b1;
      #1;
      check("t6_rst_we", fb_we, 0);
      check("t6_rst_busy", busy, 0);
      check("t6_rst_cp", charprint, 0);
      check("t6_rst_done", done, 0);
      check("t6_rst_addr", fb_addr, 0);
      check("t6_rst_data", fb_data, 0);
      check("t6_rst_char", character, 0);
      exq.delete();
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0;
      n_we = 0;
      idle_cycles(3);
      check("t6_no_we_after", n_we, 0);
      check("t6_ready", req_ready, 1);
      run_req(6'd11, 6'd20, 5'd5, 1000, 0, -1);
      check("t6_redraw_taken", n_taken, 64);
      check("t6_redraw_done", done_cyc - acc, 65);
      check("t6_first_addr", first_addr, 12960);
      check("t6_q_empty", exq.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t expected below 200000", $time);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/char_render_ctrl.md
Name: char_render_ctrl

Overview:
Sequencer that turns "draw character C at cell (col,row)" requests into 64 single-pixel writes to the video frame buffer. It drives the character bitmap memory's read enable and address, latches the returned 64-bit 8x8 glyph, and serializes the glyph row-major into frame-buffer pixel writes. It sits between the MIPS memory-mapped video register and the glyph ROM / frame buffer, and owns the glyph ROM read port exclusively.

Parameters:
NUM_CHARS, 40, number of glyphs held in the bitmap memory; codes >= NUM_CHARS draw blank
COLS, 40, character cells per text row
ROWS, 30, character rows
SCREEN_W, 320, frame-buffer width in pixels (= COLS*8)
FB_AW, 17, frame-buffer pixel address width (must hold SCREEN_W*ROWS*8-1)

Ports:
clk  in  1  system clock, all logic on posedge
reset  in  1  asynchronous, active-high reset
req_valid  in  1  draw request present
req_ready  out  1  controller can accept request (high only in IDLE)
req_char  in  6  character code
req_col  in  6  target cell column
req_row  in  5  target cell row
charprint  out  1  glyph memory read enable
character  out  6  glyph memory address
vdata  in  64  glyph bitmap; registered, valid the cycle after charprint
fb_we  out  1  pixel write strobe
fb_addr  out  FB_AW  pixel address = y*SCREEN_W + x
fb_data  out  1  pixel value
fb_stall  in  1  frame buffer busy; hold current pixel
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse, coincident with accepted final pixel write
err  out  1  one-cycle pulse on rejected request

Behaviour:
- Reset (async, any state): state=IDLE; req_ready=1 after release; charprint, fb_we, fb_data, done, err, busy=0; fb_addr, character=0; pixel counter=0; glyph register=0. In-progress draw abandoned; no further writes.
- Handshake: request accepted on posedge where req_valid && req_ready. Inputs sampled only then; later changes ignored.
- Range check at acceptance: req_col >= COLS or req_row >= ROWS -> err pulse next cycle, stay IDLE, no memory read, no writes.
- States:
  IDLE: req_ready=1. Valid in-range accept -> FETCH.
  FETCH (1 cycle): charprint=1, character=latched code. -> WAIT.
  WAIT (1 cycle): charprint=0; at end of cycle latch vdata into glyph reg, or latch 64'h0 if code >= NUM_CHARS. -> DRAW.
  DRAW: pixel index p=0..63, x=col*8+p[2:0], y=row*8+p[5:3]; fb_data=glyph[63-p] (bit 63 = top-left, row-major, MSB = leftmost pixel of row). fb_we=1 every DRAW cycle; if fb_stall=1 the write is not taken, p/addr/data held. p increments on cycles with fb_we && !fb_stall. When p=63 is taken: done=1 same cycle, -> IDLE.
- Latency, no stall: accept at edge 0; FETCH cycle 1; WAIT cycle 2; writes cycles 3..66; done in cycle 66; req_ready high again cycle 67. Min 67 cycles per request.
- fb_addr computed in full FB_AW width; no wrap (range check guarantees in bounds). Max address = SCREEN_W*ROWS*8-1.
- charprint is asserted only in FETCH; the controller never relies on vdata outside WAIT.
- Back-to-back requests: held req_valid is accepted the first IDLE cycle; no bubble beyond the IDLE cycle.
- Blank glyph (code >= NUM_CHARS) still issues all 64 writes with fb_data=0 (clears cell); no memory read.

Decomposition:
- Package video_pkg: state enum (IDLE, FETCH, WAIT, DRAW), GLYPH_W=8, GLYPH_H=8, GLYPH_BITS=64, COLS/ROWS/SCREEN_W defaults.
- One natural sub-module: glyph_serializer (64-bit load, stall-aware pixel index, bit select, last-pixel flag).
- Address arithmetic and FSM stay in the top.

Test Plan:
- Char 5 at (0,0), glyph ROM word 64'h8000_0000_0000_0001, no stall -> charprint high cycle 1 with character=5; 64 writes at addr 0..7, 320..327, ..., 2240..2247; fb_data=1 only at addr 0 and 2247; done in cycle 66.
- Char 3 at (39,29) -> first fb_addr = 29*8*320+312 = 74552, last = 76799; no err.
- req_col=40 or req_row=30 -> err pulse, no charprint, no fb_we, req_ready stays 1.
- req_char=45 (>= NUM_CHARS) at (1,1) -> no charprint; 64 writes all fb_data=0.
- fb_stall high for cycles 10..14 of DRAW -> fb_addr/fb_data frozen during stall; exactly 64 taken writes; done delayed 5 cycles.
- Reset asserted mid-DRAW at p=20 -> outputs zero asynchronously, no further fb_we; next request after release draws a full 64 pixels correctly.
